// File: rtl/mem_load_post.sv
// Load post-processing: routes the synchronous DMem/BIOS word or the IO word to the core, aligned and extended.
// Optional feature: define LOAD_IO_TIMEOUT_EN to end an IO wait as a faulting load after IO_TIMEOUT cycles.
module mem_load_post #(
    parameter int unsigned IO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en_EX,
    input  logic [2:0]  funct3_EX,
    input  logic [31:0] ALU_out,
    input  logic        stall,
    input  logic [31:0] DMem_Data_R,
    input  logic [31:0] bios_Data_R,
    input  logic [31:0] IO_Data_R,
    input  logic        IO_valid,
    output logic [31:0] Load_Data,
    output logic        Load_valid,
    output logic        Load_busy,
    output logic        Load_fault
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RESP    = 2'd1;
    localparam logic [1:0] ST_IO_WAIT = 2'd2;

    localparam logic [1:0] SP_DMEM = 2'd0;
    localparam logic [1:0] SP_BIOS = 2'd1;
    localparam logic [1:0] SP_IO   = 2'd2;
    localparam logic [1:0] SP_NONE = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] f3_q, f3_d;
    logic [1:0] off_q, off_d;
    logic [1:0] space_q, space_d;
    logic       fault_q, fault_d;

    logic [1:0]  req_space;
    logic        req_fault;
    logic        capture;
    logic        timeout_hit;
    logic [31:0] raw_word;
    logic [31:0] aligned_word;
    logic        unused_bits;

    assign unused_bits = ^ALU_out[27:2];

    function automatic logic [31:0] align_ext(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        case (ALU_out[31:28])
            4'b0001, 4'b0011: req_space = SP_DMEM;
            4'b0100:          req_space = SP_BIOS;
            4'b1000:          req_space = SP_IO;
            default:          req_space = SP_NONE;
        endcase
    end

    always_comb begin
        case (funct3_EX)
            3'b000, 3'b100: req_fault = 1'b0;
            3'b001, 3'b101: req_fault = ALU_out[0];
            3'b010:         req_fault = |ALU_out[1:0];
            default:        req_fault = 1'b1;
        endcase
        if (req_space == SP_NONE) begin
            req_fault = 1'b1;
        end
    end

    assign capture = load_en_EX && !stall && !Load_busy;

    always_comb begin
        case (space_q)
            SP_BIOS: raw_word = bios_Data_R;
            SP_IO:   raw_word = IO_Data_R;
            default: raw_word = DMem_Data_R;
        endcase
    end

    assign aligned_word = align_ext(raw_word, f3_q, off_q);

    // IO_valid wins over a timeout landing on the same cycle.
    always_comb begin
        Load_valid = 1'b0;
        Load_fault = 1'b0;
        Load_busy  = 1'b0;
        case (state_q)
            ST_RESP: begin
                Load_valid = 1'b1;
                Load_fault = fault_q;
            end
            ST_IO_WAIT: begin
                if (IO_valid) begin
                    Load_valid = 1'b1;
                end else if (timeout_hit) begin
                    Load_valid = 1'b1;
                    Load_fault = 1'b1;
                end else begin
                    Load_busy = 1'b1;
                end
            end
            default: ;
        endcase
        Load_Data = (Load_valid && !Load_fault) ? aligned_word : '0;
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        off_d   = off_q;
        space_d = space_q;
        fault_d = fault_q;
        case (state_q)
            ST_RESP:    state_d = ST_IDLE;
            ST_IO_WAIT: if (Load_valid) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (capture) begin
            f3_d    = funct3_EX;
            off_d   = ALU_out[1:0];
            space_d = req_space;
            fault_d = req_fault;
            state_d = (req_fault || req_space != SP_IO) ? ST_RESP : ST_IO_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            f3_q    <= '0;
            off_q   <= '0;
            space_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            space_q <= space_d;
            fault_q <= fault_d;
        end
    end

`ifdef LOAD_IO_TIMEOUT_EN
    localparam int unsigned CW = $clog2(IO_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q is the number of completed IO_WAIT cycles; the limit cycle is the IO_TIMEOUT-th.
    assign timeout_hit = (state_q == ST_IO_WAIT) && (cnt_q == CW'(IO_TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (!capture && state_q == ST_IO_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = IO_TIMEOUT[0];
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_post.sv
// Directed bench for mem_load_post: per-cycle comparison against a behavioural load model plus literal checks.
module tb_mem_load_post;

    localparam int unsigned TMO = 16;
`ifdef LOAD_IO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en_EX;
    logic [2:0]  funct3_EX;
    logic [31:0] ALU_out;
    logic        stall;
    logic [31:0] DMem_Data_R;
    logic [31:0] bios_Data_R;
    logic [31:0] IO_Data_R;
    logic        IO_valid;
    logic [31:0] Load_Data;
    logic        Load_valid;
    logic        Load_busy;
    logic        Load_fault;

    int errors = 0;
    int checks = 0;

    mem_load_post #(.IO_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .load_en_EX(load_en_EX), .funct3_EX(funct3_EX),
        .ALU_out(ALU_out), .stall(stall), .DMem_Data_R(DMem_Data_R),
        .bios_Data_R(bios_Data_R), .IO_Data_R(IO_Data_R), .IO_valid(IO_valid),
        .Load_Data(Load_Data), .Load_valid(Load_valid), .Load_busy(Load_busy),
        .Load_fault(Load_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend, m_io, m_fault, m_bios;
    logic [2:0]  m_f3;
    logic [31:0] m_a;
    int          m_wait;
    bit          m_to, m_busy;

    function automatic bit rule_fault(input logic [2:0] f3, input logic [31:0] a);
        int top;
        top = int'(a[31:28]);
        if (f3 == 3'd3 || f3 > 3'd5) return 1'b1;
        if (!(top == 1 || top == 3 || top == 4 || top == 8)) return 1'b1;
        return (a % (32'd1 << f3[1:0])) != 0;
    endfunction

    function automatic logic [31:0] rule_data(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [31:0] a);
        int nbytes;
        logic [31:0] v, mask;
        nbytes = 1 << f3[1:0];
        if (nbytes == 4) return w;
        v    = w >> (8 * (a % 4));
        mask = (32'd1 << (8 * nbytes)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[8 * nbytes - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit model_timeout();
        return TO_EN && m_pend && m_io && !IO_valid && (m_wait >= int'(TMO) - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 1'b0;
        end else begin
            m_to   = model_timeout();
            m_busy = m_pend && m_io && !IO_valid && !m_to;
            if (m_busy) m_wait++;
            else        m_pend = 1'b0;
            if (load_en_EX && !stall && !m_busy) begin
                m_pend  = 1'b1;
                m_wait  = 0;
                m_f3    = funct3_EX;
                m_a     = ALU_out;
                m_fault = rule_fault(funct3_EX, ALU_out);
                m_io    = (ALU_out[31:28] == 4'h8) && !m_fault;
                m_bios  = (ALU_out[31:28] == 4'h4);
            end
        end
    end

    always @(negedge clk) begin
        logic        ev, ef, eb;
        logic [31:0] ed;
        ev = 1'b0; ef = 1'b0; eb = 1'b0; ed = '0;
        if (rst_n && m_pend) begin
            if (!m_io) begin
                ev = 1'b1;
                ef = m_fault;
                ed = m_fault ? 32'd0 : rule_data(m_bios ? bios_Data_R : DMem_Data_R, m_f3, m_a);
            end else if (IO_valid) begin
                ev = 1'b1;
                ed = rule_data(IO_Data_R, m_f3, m_a);
            end else if (model_timeout()) begin
                ev = 1'b1;
                ef = 1'b1;
            end else begin
                eb = 1'b1;
            end
        end
        chk("model.valid", 32'(Load_valid), 32'(ev));
        chk("model.fault", 32'(Load_fault), 32'(ef));
        chk("model.busy",  32'(Load_busy),  32'(eb));
        chk("model.data",  Load_Data, ed);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a);
        load_en_EX = 1'b1;
        funct3_EX  = f3;
        ALU_out    = a;
        tick();
        load_en_EX = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [31:0] d,
                              input logic f, input logic b);
        #1;
        chk({nm, ".valid"}, 32'(Load_valid), 32'(v));
        chk({nm, ".data"},  Load_Data, d);
        chk({nm, ".fault"}, 32'(Load_fault), 32'(f));
        chk({nm, ".busy"},  32'(Load_busy), 32'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; load_en_EX = 1'b0; funct3_EX = '0; ALU_out = '0; stall = 1'b0;
        DMem_Data_R = '0; bios_Data_R = '0; IO_Data_R = '0; IO_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        expect_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        issue(3'b000, 32'h1000_0003); DMem_Data_R = 32'h80AB_CDEF;
        expect_out("lb_dmem", 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0); tick();
        issue(3'b100, 32'h1000_0003);
        expect_out("lbu_dmem", 1'b1, 32'h0000_0080, 1'b0, 1'b0); tick();
        issue(3'b001, 32'h4000_0002); bios_Data_R = 32'h1234_5678;
        expect_out("lh_bios", 1'b1, 32'h0000_1234, 1'b0, 1'b0); tick();
        issue(3'b101, 32'h4000_0002); bios_Data_R = 32'hF234_5678;
        expect_out("lhu_bios", 1'b1, 32'h0000_F234, 1'b0, 1'b0); tick();
        issue(3'b001, 32'h4000_0002);
        expect_out("lh_bios_neg", 1'b1, 32'hFFFF_F234, 1'b0, 1'b0); tick();
        issue(3'b010, 32'h3000_0008); DMem_Data_R = 32'hCAFE_F00D;
        expect_out("lw_dmem3", 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0); tick();

        issue(3'b010, 32'h8000_0010);
        for (int i = 0; i < 3; i++) begin
            expect_out("io_wait", 1'b0, 32'h0, 1'b0, 1'b1); tick();
        end
        IO_valid = 1'b1; IO_Data_R = 32'h89AB_CDEF;
        expect_out("io_done", 1'b1, 32'h89AB_CDEF, 1'b0, 1'b0); tick();
        IO_valid = 1'b0;
        expect_out("io_idle", 1'b0, 32'h0, 1'b0, 1'b0);

        issue(3'b010, 32'h1000_0002);
        expect_out("lw_misalign", 1'b1, 32'h0, 1'b1, 1'b0); tick();
        expect_out("lw_misalign_after", 1'b0, 32'h0, 1'b0, 1'b0);
        issue(3'b010, 32'h2000_0000);
        expect_out("lw_unmapped", 1'b1, 32'h0, 1'b1, 1'b0); tick();
        expect_out("lw_unmapped_after", 1'b0, 32'h0, 1'b0, 1'b0);
        issue(3'b001, 32'h1000_0001);
        expect_out("lh_misalign", 1'b1, 32'h0, 1'b1, 1'b0); tick();
        issue(3'b011, 32'h1000_0000);
        expect_out("f3_illegal", 1'b1, 32'h0, 1'b1, 1'b0); tick();
        issue(3'b010, 32'h8000_0002);
        expect_out("io_misalign", 1'b1, 32'h0, 1'b1, 1'b0); tick();
        expect_out("io_misalign_after", 1'b0, 32'h0, 1'b0, 1'b0);

        load_en_EX = 1'b1; funct3_EX = 3'b010; ALU_out = 32'h1000_0004;
        tick();
        funct3_EX = 3'b100; ALU_out = 32'h1000_0001; DMem_Data_R = 32'h1122_3344;
        expect_out("b2b_first", 1'b1, 32'h1122_3344, 1'b0, 1'b0); tick();
        load_en_EX = 1'b0; DMem_Data_R = 32'hAABB_CCDD;
        expect_out("b2b_second", 1'b1, 32'h0000_00CC, 1'b0, 1'b0); tick();
        expect_out("b2b_idle", 1'b0, 32'h0, 1'b0, 1'b0);

        load_en_EX = 1'b1; stall = 1'b1; funct3_EX = 3'b010; ALU_out = 32'h1000_0000;
        tick();
        load_en_EX = 1'b0; stall = 1'b0;
        expect_out("stalled", 1'b0, 32'h0, 1'b0, 1'b0);

        issue(3'b000, 32'h8000_0003);
        load_en_EX = 1'b1; funct3_EX = 3'b010; ALU_out = 32'h1000_0000;
        expect_out("busy_ignore", 1'b0, 32'h0, 1'b0, 1'b1); tick();
        load_en_EX = 1'b0; IO_valid = 1'b1; IO_Data_R = 32'h7F00_1234;
        expect_out("io_lb", 1'b1, 32'h0000_007F, 1'b0, 1'b0); tick();
        IO_valid = 1'b0;
        expect_out("busy_ignore_idle", 1'b0, 32'h0, 1'b0, 1'b0);

        issue(3'b010, 32'h8000_0000);
        expect_out("pre_reset", 1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        expect_out("rst_async", 1'b0, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        issue(3'b010, 32'h1000_0000); DMem_Data_R = 32'h0BAD_F00D;
        expect_out("post_reset_load", 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0); tick();

        issue(3'b010, 32'h8000_0020);
        if (TO_EN) begin
            for (int i = 1; i < int'(TMO); i++) begin
                expect_out("to_wait", 1'b0, 32'h0, 1'b0, 1'b1); tick();
            end
            expect_out("to_fault", 1'b1, 32'h0, 1'b1, 1'b0); tick();
            expect_out("to_idle", 1'b0, 32'h0, 1'b0, 1'b0);
        end else begin
            for (int i = 0; i < 20; i++) begin
                expect_out("long_wait", 1'b0, 32'h0, 1'b0, 1'b1); tick();
            end
            IO_valid = 1'b1; IO_Data_R = 32'h55AA_55AA;
            expect_out("long_done", 1'b1, 32'h55AA_55AA, 1'b0, 1'b0); tick();
            IO_valid = 1'b0;
            expect_out("long_idle", 1'b0, 32'h0, 1'b0, 1'b0);
        end
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
